// File: rtl/tinyriscv_pkg.sv
// Shared constants and types for the tinyriscv core: CSR addresses,
// system-instruction encodings, hold levels and the CLINT state set.
package tinyriscv_pkg;

  // Hold request levels driven toward ctrl
  localparam logic HoldEnable  = 1'b1;
  localparam logic HoldDisable = 1'b0;

  // Machine-mode CSR addresses, zero-extended to the 32-bit write bus
  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MTVEC   = 32'h0000_0305;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

  // Full 32-bit encodings of the system instructions the CLINT reacts to
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEPC,
    S_MCAUSE,
    S_MSTATUS,
    S_ASSERT,
    S_MRET
  } clint_state_e;

endpackage

// File: rtl/clint.sv
// Core-local interruptor: detects ecall/ebreak, mret and enabled async
// interrupts, holds the pipeline, sequences the mepc/mcause/mstatus writes
// and ends with a one-cycle redirect to mtvec or mepc.
module clint
  import tinyriscv_pkg::*;
#(
  parameter logic [31:0] INT_CAUSE   = 32'h8000_0007,
  parameter logic [31:0] ECALL_CAUSE = 32'd11,
  parameter logic [31:0] EBRK_CAUSE  = 32'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  int_flag_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        div_started_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        hold_flag_o,
  output logic        we_o,
  output logic [31:0] waddr_o,
  output logic [31:0] data_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  clint_state_e state_q, state_d;
  logic [31:0]  epc_q, epc_d;
  logic [31:0]  cause_q, cause_d;
  logic         we_q, we_d;
  logic [31:0]  waddr_q, waddr_d;
  logic [31:0]  data_q, data_d;
  logic         int_assert_q, int_assert_d;
  logic [31:0]  int_addr_q, int_addr_d;

  logic sync_req, mret_req, async_req, any_req;

  // Raw request decode; an instruction being flushed by an EX jump cannot trap
  always_comb begin
    sync_req  = ((inst_i == INST_ECALL) || (inst_i == INST_EBREAK)) && !jump_flag_i;
    mret_req  = (inst_i == INST_MRET);
    async_req = (|int_flag_i) && csr_mstatus_i[3] && !div_started_i;
    any_req   = sync_req || mret_req || async_req;
  end

  // Hold is combinational so the pipeline stalls in the very cycle of detection
  assign hold_flag_o = ((state_q != S_IDLE) || any_req) ? HoldEnable : HoldDisable;

  // Next state and epc/cause capture; sync beats mret beats async
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    unique case (state_q)
      S_IDLE: begin
        if (sync_req) begin
          state_d = S_MEPC;
          epc_d   = inst_addr_i;
          cause_d = (inst_i == INST_ECALL) ? ECALL_CAUSE : EBRK_CAUSE;
        end else if (mret_req) begin
          state_d = S_MRET;
        end else if (async_req) begin
          state_d = S_MEPC;
          epc_d   = jump_flag_i ? jump_addr_i : inst_addr_i;
          cause_d = INT_CAUSE;
        end
      end
      S_MEPC:    state_d = S_MCAUSE;
      S_MCAUSE:  state_d = S_MSTATUS;
      S_MSTATUS: state_d = S_ASSERT;
      S_ASSERT:  state_d = S_IDLE;
      S_MRET:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they register with it
  always_comb begin
    we_d         = 1'b0;
    waddr_d      = '0;
    data_d       = '0;
    int_assert_d = 1'b0;
    int_addr_d   = '0;
    unique case (state_d)
      S_MEPC: begin
        we_d    = 1'b1;
        waddr_d = CSR_MEPC;
        data_d  = epc_d;
      end
      S_MCAUSE: begin
        we_d    = 1'b1;
        waddr_d = CSR_MCAUSE;
        data_d  = cause_d;
      end
      S_MSTATUS: begin
        // MPIE <= MIE, MIE <= 0
        we_d    = 1'b1;
        waddr_d = CSR_MSTATUS;
        data_d  = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4],
                   1'b0, csr_mstatus_i[2:0]};
      end
      S_ASSERT: begin
        int_assert_d = 1'b1;
        int_addr_d   = csr_mtvec_i;
      end
      S_MRET: begin
        // MIE <= MPIE, MPIE <= 1, redirect to mepc in the same cycle
        we_d         = 1'b1;
        waddr_d      = CSR_MSTATUS;
        data_d       = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4],
                        csr_mstatus_i[7], csr_mstatus_i[2:0]};
        int_assert_d = 1'b1;
        int_addr_d   = csr_mepc_i;
      end
      default: ;
    endcase
  end

  // State, latches and registered outputs with synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!rst_n) begin
      state_q      <= S_IDLE;
      epc_q        <= '0;
      cause_q      <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      data_q       <= '0;
      int_assert_q <= 1'b0;
      int_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      data_q       <= data_d;
      int_assert_q <= int_assert_d;
      int_addr_q   <= int_addr_d;
    end
  end

  assign we_o         = we_q;
  assign waddr_o      = waddr_q;
  assign data_o       = data_q;
  assign int_assert_o = int_assert_q;
  assign int_addr_o   = int_addr_q;

endmodule

// File: tb/tb_clint.sv
// Self-checking bench for clint: directed trap/mret/reset scenarios then
// randomized traffic, checked by a scoreboard against a transaction-level model.
module tb_clint;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  int_flag_i;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i;
  logic        jump_flag_i, div_started_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        hold_flag_o, we_o, int_assert_o;
  logic [31:0] waddr_o, data_o, int_addr_o;

  clint dut (
    .clk(clk), .rst_n(rst_n),
    .int_flag_i(int_flag_i), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .div_started_i(div_started_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
    .hold_flag_o(hold_flag_o), .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o),
    .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [7:0]  intf;
    logic        jf;
    logic [31:0] ja;
    logic        div;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mstatus;
  } stim_t;

  // One expected output cycle: the posedge count at which it must be visible
  typedef struct {
    int          stamp;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] data;
    logic        as;
    logic [31:0] addr;
  } exp_t;

  exp_t  sb_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    busy = 0;   // cycles the model still considers the block occupied
  bit    mon_en = 1'b0;
  stim_t cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int stamp, input logic we, input logic [31:0] wa,
                      input logic [31:0] d, input logic as, input logic [31:0] a);
    exp_t e;
    e.stamp = stamp; e.we = we; e.waddr = wa; e.data = d; e.as = as; e.addr = a;
    sb_q.push_back(e);
  endtask

  // Apply one cycle of stimulus, advance the model, check the hold request
  task automatic step(input stim_t s);
    logic        exp_hold;
    logic        is_sync, is_mret, is_async;
    logic [31:0] mst;
    @(negedge clk); #2;
    rst_n         = 1'b1;
    inst_i        = s.inst;
    inst_addr_i   = s.addr;
    int_flag_i    = s.intf;
    jump_flag_i   = s.jf;
    jump_addr_i   = s.ja;
    div_started_i = s.div;
    csr_mtvec_i   = s.mtvec;
    csr_mepc_i    = s.mepc;
    csr_mstatus_i = s.mstatus;
    cur           = s;
    mst           = s.mstatus;
    exp_hold      = 1'b0;
    if (busy > 0) begin
      exp_hold = 1'b1;
      busy--;
    end else begin
      is_sync  = (s.inst == 32'h0000_0073 || s.inst == 32'h0010_0073) && !s.jf;
      is_mret  = (s.inst == 32'h3020_0073);
      is_async = (s.intf != 8'h00) && mst[3] && !s.div;
      if (is_sync || (!is_mret && is_async)) begin
        logic [31:0] epc, cause, new_mst;
        if (is_sync) begin
          epc   = s.addr;
          cause = (s.inst == 32'h0000_0073) ? 32'd11 : 32'd3;
        end else begin
          epc   = s.jf ? s.ja : s.addr;
          cause = 32'h8000_0007;
        end
        new_mst = mst;
        new_mst[7] = mst[3];
        new_mst[3] = 1'b0;
        push(cyc + 1, 1'b1, 32'h341, epc,     1'b0, 32'h0);
        push(cyc + 2, 1'b1, 32'h342, cause,   1'b0, 32'h0);
        push(cyc + 3, 1'b1, 32'h300, new_mst, 1'b0, 32'h0);
        push(cyc + 4, 1'b0, 32'h0,   32'h0,   1'b1, s.mtvec);
        busy = 4;
        exp_hold = 1'b1;
      end else if (is_mret) begin
        logic [31:0] new_mst;
        new_mst = mst;
        new_mst[3] = mst[7];
        new_mst[7] = 1'b1;
        push(cyc + 1, 1'b1, 32'h300, new_mst, 1'b1, s.mepc);
        busy = 1;
        exp_hold = 1'b1;
      end
    end
    #1 check("hold_flag", {31'b0, hold_flag_o}, {31'b0, exp_hold});
  endtask

  // Idle cycles with a NOP, CSR inputs unchanged
  task automatic idle(input int n);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s = cur;
      s.inst = 32'h0000_0013; s.intf = 8'h00; s.jf = 1'b0; s.div = 1'b0;
      step(s);
    end
  endtask

  // Pulse reset for one edge; the model abandons any sequence in flight
  task automatic reset_step();
    @(negedge clk); #2;
    rst_n = 1'b0;
    sb_q.delete();
    busy = 0;
  endtask

  function automatic stim_t mk(input logic [31:0] inst, input logic [31:0] addr,
                               input logic [7:0] intf, input logic jf, input logic [31:0] ja,
                               input logic div, input logic [31:0] mtvec,
                               input logic [31:0] mepc, input logic [31:0] mstatus);
    stim_t s;
    s.inst = inst; s.addr = addr; s.intf = intf; s.jf = jf; s.ja = ja;
    s.div = div; s.mtvec = mtvec; s.mepc = mepc; s.mstatus = mstatus;
    return s;
  endfunction

  // Monitor: every output-valid cycle must match the head of the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (we_o || int_assert_o) begin
        if (sb_q.size() == 0) begin
          check("spurious_output", {31'b0, we_o | int_assert_o}, 32'h0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("out_cycle",      cyc,                    e.stamp);
          check("we",             {31'b0, we_o},          {31'b0, e.we});
          check("waddr",          waddr_o,                e.waddr);
          check("wdata",          data_o,                 e.data);
          check("int_assert",     {31'b0, int_assert_o},  {31'b0, e.as});
          check("int_addr",       int_addr_o,             e.addr);
        end
      end else begin
        check("idle_zero", waddr_o | data_o | int_addr_o, 32'h0);
      end
    end
  end

  initial begin
    stim_t s;
    rst_n = 1'b0;
    cur = mk(32'h13, 32'h0, 8'h0, 1'b0, 32'h0, 1'b0, 32'h400, 32'h0, 32'h0);
    inst_i = 32'h13; inst_addr_i = '0; int_flag_i = '0; jump_flag_i = 1'b0;
    jump_addr_i = '0; div_started_i = 1'b0;
    csr_mtvec_i = 32'h400; csr_mepc_i = '0; csr_mstatus_i = '0;

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset_we",       {31'b0, we_o},         32'h0);
    check("reset_assert",   {31'b0, int_assert_o}, 32'h0);
    check("reset_buses",    waddr_o | data_o | int_addr_o, 32'h0);
    check("reset_hold",     {31'b0, hold_flag_o},  32'h0);
    mon_en = 1'b1;
    idle(2);

    // ecall
    step(mk(32'h0000_0073, 32'h100, 8'h00, 1'b0, 32'h0, 1'b0, 32'h400, 32'h0, 32'h8));
    idle(5);

    // Async during jump: epc comes from the jump target
    step(mk(32'h13, 32'h180, 8'h01, 1'b1, 32'h200, 1'b0, 32'h400, 32'h0, 32'h8));
    idle(5);

    // Async masked by MIE=0, then deferred by divide, then taken
    step(mk(32'h13, 32'h300, 8'h01, 1'b0, 32'h0, 1'b0, 32'h400, 32'h0, 32'h0));
    step(mk(32'h13, 32'h304, 8'h01, 1'b0, 32'h0, 1'b1, 32'h400, 32'h0, 32'h8));
    step(mk(32'h13, 32'h308, 8'h01, 1'b0, 32'h0, 1'b0, 32'h400, 32'h0, 32'h8));
    idle(5);

    // mret
    step(mk(32'h3020_0073, 32'h500, 8'h00, 1'b0, 32'h0, 1'b0, 32'h400, 32'h104, 32'h80));
    idle(2);

    // ebreak while a jump flushes it: suppressed
    step(mk(32'h0010_0073, 32'h600, 8'h00, 1'b1, 32'h700, 1'b0, 32'h400, 32'h0, 32'h8));
    // ebreak not flushed: taken, and taken despite div_started
    step(mk(32'h0010_0073, 32'h604, 8'h00, 1'b0, 32'h0, 1'b1, 32'h440, 32'h0, 32'h8));
    idle(5);

    // ecall and interrupt together: sync wins
    step(mk(32'h0000_0073, 32'h800, 8'h01, 1'b0, 32'h0, 1'b0, 32'h400, 32'h0, 32'h8));
    idle(5);

    // Reset while mcause is being written
    step(mk(32'h0000_0073, 32'h900, 8'h00, 1'b0, 32'h0, 1'b0, 32'h400, 32'h0, 32'h8));
    idle(1);
    reset_step();
    idle(1);
    check("midrst_we",     {31'b0, we_o},         32'h0);
    check("midrst_assert", {31'b0, int_assert_o}, 32'h0);
    idle(4);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      int r;
      s = cur;
      r = $urandom_range(0, 9);
      case (r)
        0:       s.inst = 32'h0000_0073;
        1:       s.inst = 32'h0010_0073;
        2:       s.inst = 32'h3020_0073;
        3, 4, 5: s.inst = 32'h0000_0013;
        default: s.inst = $urandom;
      endcase
      s.addr = $urandom;
      s.ja   = $urandom;
      s.intf = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      s.jf   = ($urandom_range(0, 3) == 0);
      s.div  = ($urandom_range(0, 3) == 0);
      if (busy == 0) begin
        s.mtvec   = $urandom;
        s.mepc    = $urandom;
        s.mstatus = $urandom;
      end
      step(s);
    end

    // Drain with a bounded number of idle cycles
    for (int i = 0; i < 20 && (busy > 0 || sb_q.size() > 0); i++) idle(1);
    idle(1);
    check("scoreboard_drained", sb_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clint.md
Name: clint

Overview:
- Core-local interruptor; the requester side of the pipeline hold/jump protocol that `ctrl` arbitrates.
- Detects synchronous traps (ecall, ebreak), asynchronous interrupts and `mret`.
- Holds the pipeline through `hold_flag_o`, then sequences the machine-mode CSR writes (mepc, mcause, mstatus).
- Finishes with a one-cycle redirect (`int_assert_o`, `int_addr_o`) to the trap vector or the return address.

Parameters:
- `INT_CAUSE`, default 32'h8000_0007, mcause value written for any asynchronous interrupt.
- `ECALL_CAUSE`, default 32'd11, mcause value written for ecall.
- `EBRK_CAUSE`, default 32'd3, mcause value written for ebreak.

Ports:
- `clk` in 1: core clock.
- `rst_n` in 1: reset.
- `int_flag_i` in 8: external/timer interrupt lines, level; any nonzero bit is a request.
- `inst_i` in 32: instruction currently in ID.
- `inst_addr_i` in 32: PC of `inst_i`.
- `jump_flag_i` in 1: EX is redirecting this cycle.
- `jump_addr_i` in 32: EX redirect target.
- `div_started_i` in 1: multi-cycle divide in flight.
- `csr_mtvec_i` in 32: current mtvec.
- `csr_mepc_i` in 32: current mepc.
- `csr_mstatus_i` in 32: current mstatus.
- `hold_flag_o` out 1: hold request toward `ctrl`; HoldEnable or HoldDisable.
- `we_o` out 1: CSR write enable.
- `waddr_o` out 32: CSR write address.
- `data_o` out 32: CSR write data.
- `int_assert_o` out 1: redirect strobe toward `ctrl`/`pc_reg`.
- `int_addr_o` out 32: redirect target.

Clocking/reset: single clock `clk`; `rst_n` synchronous, active-low.

Behaviour:
- Reset (`rst_n`=0 at an edge): state=S_IDLE; `we_o`=0, `waddr_o`=0, `data_o`=0, `int_assert_o`=0, `int_addr_o`=0; cause/epc latches=0.
- `hold_flag_o` is combinational. It is HoldEnable when state!=S_IDLE, or when state==S_IDLE and a request is detected this cycle. Otherwise it is HoldDisable.
- Request detection in S_IDLE, highest priority first:
  - (1) sync trap: `inst_i`==32'h0000_0073 (ecall) or 32'h0010_0073 (ebreak).
  - (2) mret: `inst_i`==32'h3020_0073.
  - (3) async: `int_flag_i`!=0 and `csr_mstatus_i[3]` (MIE)=1 and `div_started_i`=0.
- Sync trap is suppressed while `jump_flag_i`=1: the instruction in ID is being flushed. Async and mret are not affected by `jump_flag_i` beyond the epc selection below.
- On detection:
  - Sync: epc=`inst_addr_i`; cause=ECALL_CAUSE or EBRK_CAUSE.
  - Async: epc=`jump_addr_i` if `jump_flag_i` else `inst_addr_i`; cause=INT_CAUSE.
- Trap sequence, all outputs registered, one state per cycle:
  - S_IDLE -> S_MEPC.
  - S_MEPC: `we_o`=1, `waddr_o`=CSR_MEPC, `data_o`=epc.
  - S_MCAUSE: `we_o`=1, `waddr_o`=CSR_MCAUSE, `data_o`=cause.
  - S_MSTATUS: `we_o`=1, `waddr_o`=CSR_MSTATUS, `data_o`=`csr_mstatus_i` with bit7 (MPIE)=old bit3 and bit3=0.
  - S_ASSERT: `int_assert_o`=1, `int_addr_o`=`csr_mtvec_i`.
  - Then back to S_IDLE.
  - Total: request cycle + 4 cycles; `int_assert_o` is high exactly 1 cycle, 4 cycles after detection.
- mret sequence:
  - S_IDLE -> S_MRET.
  - S_MRET: `we_o`=1, `waddr_o`=CSR_MSTATUS, `data_o`=`csr_mstatus_i` with bit3=old bit7 and bit7=1; in the same cycle `int_assert_o`=1 and `int_addr_o`=`csr_mepc_i`.
  - Then -> S_IDLE.
- Outside the states above, `we_o`=0 and `int_assert_o`=0. `waddr_o`, `data_o` and `int_addr_o` are don't-care but are driven 0.
- Requests arriving while state!=S_IDLE are ignored, not queued. Level interrupts are re-sampled in the next S_IDLE. After a trap MIE=0, so a still-asserted `int_flag_i` does not retrigger.
- Async plus ecall in the same cycle: the sync trap wins. The interrupt stays pending, masked by MIE=0 until software re-enables it.
- `div_started_i`=1 defers async only; sync traps and mret are still taken.
- `rst_n`=0 mid-sequence: return to S_IDLE next edge, and all outputs take reset values; a partial CSR write sequence is abandoned.

Decomposition:
- In `tinyriscv_pkg`:
  - CSR address constants CSR_MEPC=12'h341, CSR_MCAUSE=12'h342, CSR_MSTATUS=12'h300, CSR_MTVEC=12'h305, zero-extended to 32 bits.
  - Instruction encodings INST_ECALL, INST_EBREAK, INST_MRET.
  - typedef enum `clint_state_e` {S_IDLE, S_MEPC, S_MCAUSE, S_MSTATUS, S_ASSERT, S_MRET}.
  - Reuse of the existing HoldEnable/HoldDisable.
- Single module; no sub-module is needed.

Test Plan:
- Reset then idle: `rst_n`=0 for 2 cycles, `inst_i`=NOP -> all outputs 0, `hold_flag_o`=HoldDisable.
- ecall: `inst_i`=32'h73, `inst_addr_i`=32'h100, mstatus=32'h8, mtvec=32'h400 -> hold asserted immediately. Writes appear in order: 341<-100, then 342<-0000_000B, then 300<-0000_0080. `int_assert_o` with `int_addr_o`=32'h400 on cycle 4.
- Async during jump: `int_flag_i`=8'h01, MIE=1, `jump_flag_i`=1, `jump_addr_i`=32'h200 -> mepc<-200, mcause<-8000_0007.
- Async masked/deferred: MIE=0, or `div_started_i`=1, with `int_flag_i`=8'h01 -> no hold and no writes. Deasserting `div_started_i` with MIE=1 -> the trap is taken the next cycle.
- mret: `inst_i`=32'h3020_0073, mstatus=32'h80, mepc=32'h104 -> one cycle with 300<-0000_0088, `int_assert_o`=1, `int_addr_o`=32'h104.
- Priority/reset: ecall and `int_flag_i` together -> mcause=0000_000B. Assert `rst_n`=0 in S_MCAUSE -> next cycle S_IDLE, `we_o`=0, no `int_assert_o`.
